// File: rtl/sha256_buf_pkg.sv
// Shared types and widths for the SHA-256 message buffer and its word RAM.
package sha256_buf_pkg;

    localparam int DIGEST_WORDS = 8;
    localparam int WORD_W       = 32;
    localparam int ADDR_W       = 16;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_UNLOAD
    } state_e;

endpackage

// File: rtl/sha256_word_ram.sv
// Shared word RAM: one write port, a registered engine read port and a
// combinational read port for draining the digest.
module sha256_word_ram
    import sha256_buf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic [AW-1:0]     caddr,
    output logic [WORD_W-1:0] cdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    // Out-of-range reads return zero rather than an aliased word.
    always_comb begin
        rdata_d = '0;
        if (rd_en) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = rdata_q;
    assign cdata = mem_q[caddr];

endmodule

// File: rtl/sha256_msg_buffer.sv
// Memory-side partner of the SHA-256 engine: loads a message from the host,
// kicks the engine, serves its memory bus and streams the digest back out.
module sha256_msg_buffer
    import sha256_buf_pkg::*;
#(
    parameter int                NUM_OF_WORDS = 20,
    parameter int                DEPTH        = 64,
    parameter logic [ADDR_W-1:0] MSG_BASE     = 16'h0000,
    parameter logic [ADDR_W-1:0] OUT_BASE     = 16'h0020,
    parameter int                BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              start,
    input  logic              done,
    output logic [ADDR_W-1:0] message_addr,
    output logic [ADDR_W-1:0] output_addr,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_write_data,
    output logic [WORD_W-1:0] mem_read_data,
    output logic              busy,
    output logic              err
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam int N_W    = $clog2(NUM_OF_WORDS);
    localparam int K_W    = $clog2(DIGEST_WORDS);
    localparam int T_W    = $clog2(BUSY_TIMEOUT) + 1;

    state_e           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [T_W-1:0]   tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             start_q, start_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic              in_load, mem_in_range, host_we, eng_we;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr, host_addr, dig_addr;
    logic [WORD_W-1:0] ram_wdata;

    assign in_load      = (state_q == ST_LOAD);
    assign mem_in_range = (mem_addr < ADDR_W'(DEPTH));
    assign host_we      = in_load && in_valid;
    assign eng_we       = !in_load && mem_we && mem_in_range;
    assign host_addr    = RAM_AW'(MSG_BASE) + RAM_AW'(n_q);
    assign dig_addr     = RAM_AW'(OUT_BASE) + RAM_AW'(k_q);

    // The host owns the write port while loading; the engine owns it otherwise.
    always_comb begin
        ram_we    = host_we | eng_we;
        ram_waddr = in_load ? host_addr : mem_addr[RAM_AW-1:0];
        ram_wdata = in_load ? in_data   : mem_write_data;
    end

    sha256_word_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .rd_en   (mem_in_range),
        .raddr   (mem_addr[RAM_AW-1:0]),
        .rdata   (mem_read_data),
        .caddr   (dig_addr),
        .cdata   (out_data)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (n_q == N_W'(NUM_OF_WORDS - 1)) begin
                        n_d     = '0;
                        state_d = ST_KICK;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            ST_KICK: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // An engine that never leaves idle aborts the job without unloading.
                if (!done) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == T_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    k_d     = '0;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_W'(DIGEST_WORDS - 1)) state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (!mem_in_range || (mem_we && in_load)) err_d = 1'b1;

        in_ready_d  = (state_d == ST_LOAD);
        start_d     = (state_d == ST_KICK);
        out_valid_d = (state_d == ST_UNLOAD);
        busy_d      = (state_d != ST_LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            n_q         <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign start        = start_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign message_addr = MSG_BASE;
    assign output_addr  = OUT_BASE;

endmodule

// File: tb/tb_sha256_msg_buffer.sv
// Directed bench for sha256_msg_buffer with a word-level RAM/error model
// compared every cycle, plus literal expectations for each scenario.
module tb_sha256_msg_buffer;

    logic        clk, reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        start, done, mem_we, busy, err;
    logic [15:0] message_addr, output_addr, mem_addr;
    logic [31:0] mem_write_data, mem_read_data;

    sha256_msg_buffer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .start          (start),
        .done           (done),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Word-level model: the bench declares who may write (host_ok/eng_ok),
    // the model tracks RAM contents, the read register and protocol errors.
    logic [31:0] mram [64];
    bit          mvalid [64];
    logic [31:0] m_rd;
    bit          m_rd_known, m_err_proto, m_err_tmo;
    bit          host_ok, eng_ok;
    int          m_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rd        <= 32'h0;
            m_rd_known  <= 1'b1;
            m_err_proto <= 1'b0;
            m_n         <= 0;
        end else begin
            if (mem_addr >= 16'd64) begin
                m_rd       <= 32'h0;
                m_rd_known <= 1'b1;
                m_err_proto <= 1'b1;
            end else begin
                m_rd       <= mram[mem_addr[5:0]];
                m_rd_known <= mvalid[mem_addr[5:0]];
            end
            if (mem_we && !eng_ok) m_err_proto <= 1'b1;
            if (mem_we && eng_ok && mem_addr < 16'd64) begin
                mram[mem_addr[5:0]]   <= mem_write_data;
                mvalid[mem_addr[5:0]] <= 1'b1;
            end
            if (in_valid && host_ok) begin
                mram[m_n]   <= in_data;
                mvalid[m_n] <= 1'b1;
                m_n         <= (m_n == 19) ? 0 : m_n + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: compare against the model on the falling edge, then return
    // just after the next rising edge with inputs free to change.
    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            if (m_rd_known) chk("rd_model", mem_read_data, m_rd);
            chk1("err_model", err, m_err_proto | m_err_tmo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [31:0] base);
        host_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            chk1("in_ready_load", in_ready, 1'b1);
            chk1("start_idle", start, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        host_ok  = 1'b0;
        chk1("start_pulse", start, 1'b1);
        chk1("in_ready_kick", in_ready, 1'b0);
        chk1("busy_kick", busy, 1'b1);
    endtask

    task automatic kick_engine();
        done   = 1'b0;
        eng_ok = 1'b1;
        tick();
        chk1("start_once", start, 1'b0);
        tick();
        chk1("out_valid_wait", out_valid, 1'b0);
        chk1("busy_wait", busy, 1'b1);
    endtask

    task automatic readback(input logic [31:0] base);
        for (int i = 0; i < 20; i++) begin
            mem_addr = 16'(i);
            tick();
            chk("ram_msg", mem_read_data, base + 32'(i));
        end
        mem_addr = 16'h0;
    endtask

    task automatic eng_write_digest(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            mem_we         = 1'b1;
            mem_addr       = 16'(32 + i);
            mem_write_data = base + 32'(i);
            tick();
        end
        mem_we   = 1'b0;
        mem_addr = 16'h0;
    endtask

    task automatic finish_engine(input logic [31:0] base);
        chk1("out_valid_pre_done", out_valid, 1'b0);
        done = 1'b1;
        tick();
        chk1("out_valid_first", out_valid, 1'b1);
        chk("out_data_first", out_data, base);
    endtask

    task automatic unload(input logic [31:0] base, input bit stall, input int nhs);
        for (int k = 0; k < nhs; k++) begin
            if (stall) begin
                out_ready = 1'b0;
                chk1("out_valid_stall", out_valid, 1'b1);
                chk("out_data", out_data, base + 32'(k));
                tick();
                chk("out_data_hold", out_data, base + 32'(k));
            end
            out_ready = 1'b1;
            chk1("out_valid", out_valid, 1'b1);
            chk("out_data", out_data, base + 32'(k));
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic expect_load(input string name);
        chk1({name, "_in_ready"}, in_ready, 1'b1);
        chk1({name, "_out_valid"}, out_valid, 1'b0);
        chk1({name, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
        host_ok = 1'b0; eng_ok = 1'b0; m_err_tmo = 1'b0;
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_start", start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_rd", mem_read_data, 32'h0);
        chk("message_addr", 32'(message_addr), 32'h0000);
        chk("output_addr", 32'(output_addr), 32'h0020);
        reset_n = 1'b1;
        tick();

        // Job 1: load 1..20, engine reads, read-during-write, stalled unload.
        load_job(32'h1);
        kick_engine();
        readback(32'h1);
        mem_addr = 16'd5;
        tick();
        chk("rd_latency", mem_read_data, 32'h6);
        mem_we = 1'b1; mem_write_data = 32'hDEADBEEF;
        tick();
        mem_we = 1'b0;
        chk("rd_during_wr_old", mem_read_data, 32'h6);
        tick();
        chk("rd_after_wr", mem_read_data, 32'hDEADBEEF);
        mem_addr = 16'h0;
        eng_write_digest(32'hA0);
        finish_engine(32'hA0);
        unload(32'hA0, 1'b1, 8);
        eng_ok = 1'b0;
        expect_load("job1_done");

        // Job 2 back-to-back: engine never drops done, so the job times out.
        load_job(32'h100);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk1("tmo_err_pending", err, 1'b0);
            chk1("tmo_out_valid", out_valid, 1'b0);
            chk1("tmo_in_ready", in_ready, 1'b0);
        end
        tick();
        m_err_tmo = 1'b1;
        chk1("tmo_err", err, 1'b1);
        expect_load("tmo_load");
        tick();
        chk1("tmo_no_unload", out_valid, 1'b0);

        // Job 3: reset after three digest handshakes.
        load_job(32'h200);
        kick_engine();
        eng_write_digest(32'hB0);
        finish_engine(32'hB0);
        unload(32'hB0, 1'b0, 3);
        chk1("pre_rst_out_valid", out_valid, 1'b1);
        chk("pre_rst_out_data", out_data, 32'hB3);
        reset_n = 1'b0; m_err_tmo = 1'b0; eng_ok = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_start", start, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk("midrst_out_data", out_data, 32'hB0);
        #1;
        reset_n = 1'b1;
        tick();

        // Job 4: fresh job after reset completes normally.
        load_job(32'h300);
        kick_engine();
        readback(32'h300);
        eng_write_digest(32'hC0);
        finish_engine(32'hC0);
        unload(32'hC0, 1'b1, 8);
        eng_ok = 1'b0;
        expect_load("job4_done");
        chk1("err_clean", err, 1'b0);

        // Protocol errors: engine write while loading, then out-of-range read.
        mem_we = 1'b1; mem_addr = 16'd3; mem_write_data = 32'hFFFFFFFF;
        tick();
        mem_we = 1'b0;
        chk1("err_load_write", err, 1'b1);
        tick();
        chk("load_write_dropped", mem_read_data, 32'h303);
        mem_addr = 16'd64;
        tick();
        chk("oob_read_zero", mem_read_data, 32'h0);
        mem_addr = 16'h0;
        tick();
        tick();
        chk1("err_sticky", err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
